load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I width codes, FSM states and
// request-decode helpers used by load_store_unit and lsu_align.
package lsu_pkg;

    // Load width/sign codes (req_write = 0)
    typedef enum logic [2:0] {
        F3Lb  = 3'b000,
        F3Lh  = 3'b001,
        F3Lw  = 3'b010,
        F3Lbu = 3'b100,
        F3Lhu = 3'b101
    } lsu_load_f3_t;

    // Store width codes (req_write = 1)
    typedef enum logic [2:0] {
        F3Sb = 3'b000,
        F3Sh = 3'b001,
        F3Sw = 3'b010
    } lsu_store_f3_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } lsu_state_t;

    // Width code is a real load or store encoding
    function automatic logic f3_legal(logic write, logic [2:0] f3);
        if (write) begin
            return f3 inside {3'b000, 3'b001, 3'b010};
        end
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    // Halfword on an odd byte, or word off a word boundary
    function automatic logic f3_misaligned(logic [2:0] f3, logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: positions store data/strobes on the 32-bit bus
// and extracts/extends load data from a memory word. Halfword lane choice
// uses only off[1] and word accesses ignore the offset, so misaligned low
// bits are naturally dropped when no trap is taken.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store strobes and replicated write data
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = st_data;
        case (st_funct3)
            F3Sb: begin
                st_wstrb = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            F3Sh: begin
                st_wstrb = st_offset[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            F3Sw: begin
                st_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        ld_byte = ld_rdata[7:0];
        unique case (ld_offset)
            2'd0: ld_byte = ld_rdata[7:0];
            2'd1: ld_byte = ld_rdata[15:8];
            2'd2: ld_byte = ld_rdata[23:16];
            2'd3: ld_byte = ld_rdata[31:24];
            default: ;
        endcase
        ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3Lb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3Lbu:   ld_data = {24'h0, ld_byte};
            F3Lh:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3Lhu:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, IDLE -> ACCESS -> (WAIT) -> RESP.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses with
// rsp_err; otherwise misaligned low address bits are dropped.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata
);

    // WAIT counts down from MEM_LATENCY-1; leaving on zero gives MEM_LATENCY cycles
    localparam logic [2:0] LatInit = 3'(MEM_LATENCY - 1);

    lsu_state_t        state_q, state_d;
    logic              is_write_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic [2:0]        cnt_q;
    logic              mem_wren_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic              req_err;
    logic [3:0]        st_wstrb;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;

    assign req_ready = (state_q == StIdle);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = !f3_legal(req_write, req_funct3) ||
                     f3_misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_err = !f3_legal(req_write, req_funct3);
`endif

    lsu_align u_align (
        .st_funct3 (req_funct3),
        .st_offset (req_addr[1:0]),
        .st_data   (req_wdata),
        .st_wstrb  (st_wstrb),
        .st_wdata  (st_wdata),
        .ld_funct3 (funct3_q),
        .ld_offset (offset_q),
        .ld_rdata  (mem_rdata),
        .ld_data   (ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rejected requests skip straight to the response
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_valid) state_d = req_err ? StResp : StAccess;
            StAccess: state_d = is_write_q ? StResp : StWait;
            StWait:   if (cnt_q == 3'd0) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Request capture, memory-side outputs, latency counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write_q  <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            cnt_q       <= 3'd0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            mem_wren_q  <= 1'b0;
            rsp_valid_q <= (state_d == StResp);
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (req_err) begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            is_write_q  <= req_write;
                            funct3_q    <= req_funct3;
                            offset_q    <= req_addr[1:0];
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wren_q  <= req_write;
                            mem_wstrb_q <= req_write ? st_wstrb : 4'b0000;
                            if (req_write) begin
                                mem_wdata_q <= st_wdata;
                            end
                        end
                    end
                end
                StAccess: begin
                    mem_wstrb_q <= 4'b0000;
                    cnt_q       <= LatInit;
                    if (is_write_q) begin
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd0) begin
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= ld_data;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wren  = mem_wren_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: two instances (MEM_LATENCY 1 and 3)
// share the request and memory inputs. Expectations follow LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_rdata;

    logic        r1_ready, r1_rsp_valid, r1_rsp_err, r1_wren;
    logic [31:0] r1_rdata, r1_addr, r1_wdata;
    logic [3:0]  r1_wstrb;
    logic        r3_ready, r3_rsp_valid, r3_rsp_err, r3_wren;
    logic [31:0] r3_rdata, r3_addr, r3_wdata;
    logic [3:0]  r3_wstrb;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LATENCY(1), .ADDR_W(32)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (r1_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (r1_rsp_valid),
        .rsp_rdata  (r1_rdata),
        .rsp_err    (r1_rsp_err),
        .mem_wren   (r1_wren),
        .mem_addr   (r1_addr),
        .mem_wdata  (r1_wdata),
        .mem_wstrb  (r1_wstrb),
        .mem_rdata  (mem_rdata)
    );

    load_store_unit #(.MEM_LATENCY(3), .ADDR_W(32)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (r3_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (r3_rsp_valid),
        .rsp_rdata  (r3_rdata),
        .rsp_err    (r3_rsp_err),
        .mem_wren   (r3_wren),
        .mem_addr   (r3_addr),
        .mem_wdata  (r3_wdata),
        .mem_wstrb  (r3_wstrb),
        .mem_rdata  (mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the last run_req, sampled each cycle on the falling edge
    int          lat1, lat3, rsp1, rsp3, wren1, wren3;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_wstrb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, then watch both DUTs for 10 cycles.
    // Latency k: rsp_valid is high in the k-th cycle after the handshake edge.
    task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        mem_rdata  = rd;
        check({tag, "/ready"}, 32'({r1_ready, r3_ready}), 32'd3);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat1 = 0; lat3 = 0; rsp1 = 0; rsp3 = 0; wren1 = 0; wren3 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                acc_addr  = r1_addr;
                acc_wdata = r1_wdata;
                acc_wstrb = r1_wstrb;
            end
            if (r1_rsp_valid) begin
                if (lat1 == 0) lat1 = k;
                rsp1++;
            end
            if (r3_rsp_valid) begin
                if (lat3 == 0) lat3 = k;
                rsp3++;
            end
            if (r1_wren) wren1++;
            if (r3_wren) wren3++;
        end
    endtask

    task automatic expect_txn(input string tag, input int e_lat1, input int e_lat3,
                              input int e_wren, input logic [31:0] e_rdata,
                              input logic e_err);
        check({tag, "/lat1"},   lat1, e_lat1);
        check({tag, "/lat3"},   lat3, e_lat3);
        check({tag, "/rsp1"},   rsp1, 1);
        check({tag, "/rsp3"},   rsp3, 1);
        check({tag, "/wren1"},  wren1, e_wren);
        check({tag, "/wren3"},  wren3, e_wren);
        check({tag, "/rdata1"}, r1_rdata, e_rdata);
        check({tag, "/rdata3"}, r3_rdata, e_rdata);
        check({tag, "/err1"},   32'(r1_rsp_err), 32'(e_err));
        check({tag, "/err3"},   32'(r3_rsp_err), 32'(e_err));
    endtask

    int hs1, hs3, rspc, wrc, ovl, bad;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_rdata  = 32'h0;

        // Reset state, before any clock edge
        #3;
        check("rst/ready",  32'({r1_ready, r3_ready}), 32'd3);
        check("rst/rspv",   32'({r1_rsp_valid, r3_rsp_valid}), 32'd0);
        check("rst/err",    32'({r1_rsp_err, r3_rsp_err}), 32'd0);
        check("rst/rdata",  r1_rdata | r3_rdata, 32'h0);
        check("rst/wren",   32'({r1_wren, r3_wren}), 32'd0);
        check("rst/wstrb",  32'({r1_wstrb, r3_wstrb}), 32'd0);
        check("rst/addr",   r1_addr | r3_addr, 32'h0);
        check("rst/wdata",  r1_wdata | r3_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // SB at byte 3
        run_req("sb", 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0);
        expect_txn("sb", 2, 2, 1, 32'h0, 1'b0);
        check("sb/addr",  acc_addr,  32'h0000_1000);
        check("sb/wstrb", 32'(acc_wstrb), 32'h8);
        check("sb/wdata", acc_wdata, 32'hABAB_ABAB);

        // SH upper half
        run_req("sh", 1'b1, 3'b001, 32'h0000_1002, 32'h0000_1234, 32'h0);
        expect_txn("sh", 2, 2, 1, 32'h0, 1'b0);
        check("sh/wstrb", 32'(acc_wstrb), 32'hC);
        check("sh/wdata", acc_wdata, 32'h1234_1234);

        // Byte loads from lane 1
        run_req("lb", 1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_F000);
        expect_txn("lb", 3, 5, 0, 32'hFFFF_FFF0, 1'b0);
        check("lb/addr", acc_addr, 32'h0000_2000);
        run_req("lbu", 1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_F000);
        expect_txn("lbu", 3, 5, 0, 32'h0000_00F0, 1'b0);

        // Halfword loads from the upper half
        run_req("lh", 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000);
        expect_txn("lh", 3, 5, 0, 32'hFFFF_8001, 1'b0);
        run_req("lhu", 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000);
        expect_txn("lhu", 3, 5, 0, 32'h0000_8001, 1'b0);

        // SW moves mem_addr away from 0x2000
        run_req("sw", 1'b1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0);
        expect_txn("sw", 2, 2, 1, 32'h0, 1'b0);
        check("sw/addr",  acc_addr, 32'h0000_3000);
        check("sw/wstrb", 32'(acc_wstrb), 32'hF);
        check("sw/wdata", acc_wdata, 32'hDEAD_BEEF);

        // Misaligned LW
        run_req("lw_mis", 1'b0, 3'b010, 32'h0000_2002, 32'h0, 32'h1122_3344);
`ifdef LSU_MISALIGN_TRAP_EN
        expect_txn("lw_mis", 1, 1, 0, 32'h0, 1'b1);
        check("lw_mis/addr", acc_addr, 32'h0000_3000);
`else
        expect_txn("lw_mis", 3, 5, 0, 32'h1122_3344, 1'b0);
        check("lw_mis/addr", acc_addr, 32'h0000_2000);
`endif

        // Illegal width codes are rejected without touching memory
        run_req("ld_f3_011", 1'b0, 3'b011, 32'h0000_4000, 32'h0, 32'h5555_5555);
        expect_txn("ld_f3_011", 1, 1, 0, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
        check("ld_f3_011/addr", r1_addr, 32'h0000_3000);
`else
        check("ld_f3_011/addr", r1_addr, 32'h0000_2000);
`endif
        run_req("st_f3_100", 1'b1, 3'b100, 32'h0000_4000, 32'h77, 32'h0);
        expect_txn("st_f3_100", 1, 1, 0, 32'h0, 1'b1);

        // Next good response clears rsp_err
        run_req("lw", 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D);
        expect_txn("lw", 3, 5, 0, 32'hCAFE_F00D, 1'b0);

        // Reset while both DUTs sit in WAIT of a load
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0000_2001; mem_rdata = 32'h0000_F000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_wait/rspv",  32'({r1_rsp_valid, r3_rsp_valid}), 32'd0);
        check("rst_wait/ready", 32'({r1_ready, r3_ready}), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (r1_rsp_valid || r3_rsp_valid || r1_wren || r3_wren) bad++;
        end
        check("rst_wait/quiet", bad, 0);
        check("rst_wait/ready_after", 32'({r1_ready, r3_ready}), 32'd3);

        // Reset while a store is in ACCESS: the write strobe drops at once
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_7000; req_wdata = 32'h1357_9BDF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_acc/wren_before", 32'({r1_wren, r3_wren}), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("rst_acc/wren_after",  32'({r1_wren, r3_wren}), 32'd0);
        check("rst_acc/wstrb_after", 32'({r1_wstrb, r3_wstrb}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (r1_rsp_valid || r3_rsp_valid || r1_wren || r3_wren) bad++;
        end
        check("rst_acc/quiet", bad, 0);
        check("rst_acc/ready_after", 32'({r1_ready, r3_ready}), 32'd3);

        // req_valid held high: stores accepted every third cycle, only in IDLE
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_6000; req_wdata = 32'h0000_0001;
        hs1 = 0; hs3 = 0; rspc = 0; wrc = 0; ovl = 0;
        for (int k = 0; k < 9; k++) begin
            if (r1_ready) hs1++;
            if (r3_ready) hs3++;
            if (r1_rsp_valid) rspc++;
            if (r1_wren) wrc++;
            if (r1_ready && r1_rsp_valid) ovl++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b/hs1",     hs1, 3);
        check("b2b/hs3",     hs3, 3);
        check("b2b/rsp",     rspc, 3);
        check("b2b/wren",    wrc, 3);
        check("b2b/overlap", ovl, 0);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
